// File: rtl/pps_capture.sv
// rtl/pps_capture.sv - PPS capture and removal stage for the slice word stream
// Ports:
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   flush          : synchronous clear of everything except the stored pps
//   in_data        : input word (DATA_WIDTH bits)
//   in_valid       : input word strobe, no backpressure
//   in_sof/in_eof  : frame markers for the input word
//   in_data_is_pps : input word belongs to the PPS
//   pps            : captured PPS, word 0 in the MSBs
//   pps_valid      : one-cycle pulse when pps is updated
//   pps_loaded     : high while a complete PPS is held
//   out_data/out_valid/out_sof/out_eof : input stream with PPS words removed, 1 cycle later
//   pps_err        : sticky protocol-error flag
module pps_capture #(
  parameter int DATA_WIDTH = 256,
  parameter int PPS_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic                            in_eof,
  input  logic                            in_data_is_pps,
  output logic [DATA_WIDTH*PPS_WORDS-1:0] pps,
  output logic                            pps_valid,
  output logic                            pps_loaded,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            out_sof,
  output logic                            out_eof,
  output logic                            pps_err
);

  localparam int CW = $clog2(PPS_WORDS) + 1;
  localparam int IW = (PPS_WORDS > 1) ? $clog2(PPS_WORDS) : 1;
  localparam int PW = DATA_WIDTH * PPS_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shadow [PPS_WORDS];
  logic [PW-1:0]         shadow_flat;
  logic                  shadow_we;
  logic [IW-1:0]         shadow_idx;
  logic                  copy;
  logic                  fwd;
  logic                  err_set;
  logic                  pps_word;
  logic                  data_word;
  logic                  complete;

  assign pps_word  = in_valid & in_data_is_pps;
  assign data_word = in_valid & ~in_data_is_pps;

  // The last PPS word was stored on the previous edge; this cycle copies the
  // shadow out and the block already behaves as RUN for the incoming word.
  assign complete = (state == CAPT) && (cnt == CW'(PPS_WORDS));

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < PPS_WORDS; i++) begin
      shadow_flat[PW-1-i*DATA_WIDTH -: DATA_WIDTH] = shadow[i];
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shadow_we  = 1'b0;
    shadow_idx = '0;
    copy       = 1'b0;
    fwd        = 1'b0;
    err_set    = 1'b0;

    if (state == RUN || complete) begin
      copy    = complete;
      state_n = RUN;
      cnt_n   = '0;
      if (pps_word && in_sof) begin
        shadow_we = 1'b1;
        cnt_n     = CW'(1);
        state_n   = CAPT;
      end else if (pps_word) begin
        err_set = 1'b1;
      end else if (data_word) begin
        fwd = 1'b1;
      end
    end else if (state == CAPT) begin
      if (pps_word && in_sof) begin
        // restart at word 0
        shadow_we = 1'b1;
        cnt_n     = CW'(1);
        err_set   = 1'b1;
      end else if (pps_word) begin
        shadow_we  = 1'b1;
        shadow_idx = cnt[IW-1:0];
        cnt_n      = cnt + CW'(1);
      end else if (data_word) begin
        // abort: fall back to whatever pps is still valid
        err_set = 1'b1;
        cnt_n   = '0;
        state_n = pps_loaded ? RUN : IDLE;
      end
    end else begin
      state_n = IDLE;
      if (pps_word && in_sof) begin
        shadow_we = 1'b1;
        cnt_n     = CW'(1);
        state_n   = CAPT;
      end else if (pps_word) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pps        <= '0;
      pps_valid  <= 1'b0;
      pps_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      pps_err    <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      pps_valid  <= 1'b0;
      pps_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      pps_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pps_valid  <= copy;
      if (copy) begin
        pps <= shadow_flat;
      end
      pps_loaded <= pps_loaded | copy;
      out_valid  <= fwd;
      out_sof    <= fwd & in_sof;
      out_eof    <= fwd & in_eof;
      pps_err    <= pps_err | err_set;
    end
  end

  // Datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (!flush && shadow_we) begin
      shadow[shadow_idx] <= in_data;
    end
    if (!flush && fwd) begin
      out_data <= in_data;
    end
  end

endmodule

// File: tb/tb_pps_capture.sv
// tb/tb_pps_capture.sv - randomized self-checking bench for pps_capture
module tb_pps_capture;

  localparam int DW = 256;
  localparam int PW = 4;

  localparam logic [DW-1:0] WA = {64{4'hA}};
  localparam logic [DW-1:0] WB = {64{4'hB}};
  localparam logic [DW-1:0] WC = {64{4'hC}};
  localparam logic [DW-1:0] WD = {64{4'hD}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic             in_eof = 1'b0;
  logic             in_data_is_pps = 1'b0;
  logic [DW*PW-1:0] pps;
  logic             pps_valid;
  logic             pps_loaded;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             pps_err;

  pps_capture #(.DATA_WIDTH(DW), .PPS_WORDS(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_eof         (in_eof),
    .in_data_is_pps (in_data_is_pps),
    .pps            (pps),
    .pps_valid      (pps_valid),
    .pps_loaded     (pps_loaded),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .pps_err        (pps_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: words collected so far, held PPS, expected outputs
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pps [PW];
  bit            m_capt, m_pend, m_loaded, m_err;
  bit            e_pv, e_ov, e_sof, e_eof;
  logic [DW-1:0] e_data;
  bit            have_data = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_step(input bit r, input bit f, input bit v, input bit p,
                            input bit s, input bit e, input logic [DW-1:0] d);
    e_pv = 0; e_ov = 0; e_sof = 0; e_eof = 0;
    if (!r || f) begin
      m_q.delete();
      m_capt = 0; m_pend = 0; m_loaded = 0; m_err = 0;
      if (!r) foreach (m_pps[i]) m_pps[i] = '0;
      return;
    end
    if (m_pend) begin
      foreach (m_pps[i]) m_pps[i] = m_q[i];
      e_pv = 1; m_loaded = 1; m_pend = 0; m_capt = 0;
      m_q.delete();
    end
    if (!v) return;
    if (p) begin
      if (s) begin
        if (m_capt) m_err = 1;
        m_q.delete();
        m_q.push_back(d);
        m_capt = 1;
      end else if (m_capt) begin
        m_q.push_back(d);
      end else begin
        m_err = 1;
      end
      if (m_capt && m_q.size() == PW) m_pend = 1;
    end else begin
      if (m_capt) begin
        m_err = 1; m_capt = 0;
        m_q.delete();
      end else if (m_loaded) begin
        e_ov = 1; e_sof = s; e_eof = e; e_data = d; have_data = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("pps_valid", DW'(pps_valid), DW'(e_pv));
    chk("pps_loaded", DW'(pps_loaded), DW'(m_loaded));
    chk("pps_err", DW'(pps_err), DW'(m_err));
    chk("out_valid", DW'(out_valid), DW'(e_ov));
    chk("out_sof", DW'(out_sof), DW'(e_sof));
    chk("out_eof", DW'(out_eof), DW'(e_eof));
    if (have_data) chk("out_data", out_data, e_data);
    for (int i = 0; i < PW; i++)
      chk($sformatf("pps_w%0d", i), pps[DW*(PW-i)-1 -: DW], m_pps[i]);
  endtask

  task automatic do_cycle(input bit r, input bit f, input bit v, input bit p,
                          input bit s, input bit e, input logic [DW-1:0] d);
    @(negedge clk);
    check_outputs();
    rst_n = r; flush = f; in_valid = v; in_data_is_pps = p;
    in_sof = s; in_eof = e; in_data = d;
    model_step(r, f, v, p, s, e, d);
  endtask

  task automatic word(input bit p, input bit s, input bit e, input logic [DW-1:0] d);
    do_cycle(1'b1, 1'b0, 1'b1, p, s, e, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw());
  endtask

  task automatic send_pps(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    word(1, 1, 0, w0);
    word(1, 0, 0, w1);
    word(1, 0, 1, w2);
    word(1, 0, 0, w3);
  endtask

  initial begin
    model_step(0, 0, 0, 0, 0, 0, '0);
    do_cycle(0, 0, 0, 0, 0, 0, '0);
    do_cycle(0, 0, 1, 1, 1, 0, rw());
    idle(2);

    // four PPS words then a three-word data frame
    send_pps(WA, WB, WC, WD);
    word(0, 1, 0, rw());
    word(0, 0, 0, rw());
    word(0, 0, 1, rw());
    idle(3);

    // second PPS while one is loaded
    send_pps(rw(), rw(), rw(), rw());
    idle(3);

    // short PPS aborted by a data word from IDLE
    do_cycle(1, 1, 0, 0, 0, 0, rw());
    word(1, 1, 0, rw());
    word(1, 0, 0, rw());
    word(0, 1, 1, rw());
    idle(2);

    // flush together with a valid word mid-capture, then a full capture
    word(1, 1, 0, rw());
    word(1, 0, 0, rw());
    do_cycle(1, 1, 1, 1, 0, 0, rw());
    idle(1);
    send_pps(rw(), rw(), rw(), rw());
    word(0, 1, 1, rw());
    idle(2);

    // data word in IDLE, then PPS word without sof
    do_cycle(1, 1, 0, 0, 0, 0, rw());
    word(0, 1, 1, rw());
    word(1, 0, 0, rw());
    idle(2);

    // reset after PPS word 2
    do_cycle(1, 1, 0, 0, 0, 0, rw());
    word(1, 1, 0, rw());
    word(1, 0, 0, rw());
    do_cycle(0, 0, 0, 0, 0, 0, rw());
    idle(4);
    word(1, 0, 0, rw());
    idle(2);

    // randomized bursts
    for (int b = 0; b < 400; b++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 3) begin
        for (int i = 0; i < int'($urandom_range(1, 2)); i++)
          do_cycle(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, rw());
      end else if (k < 8) begin
        do_cycle(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, rw());
      end else if (k < 45) begin
        int n;
        n = ($urandom_range(0, 9) < 8) ? PW : int'($urandom_range(1, PW + 1));
        for (int i = 0; i < n; i++) begin
          bit s;
          s = (i == 0);
          if ($urandom_range(0, 19) == 0) s = ~s;
          word(1, s, $urandom_range(0, 1), rw());
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end else if (k < 85) begin
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
          word(0, i == 0, i == n - 1, rw());
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end else begin
        word($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), rw());
      end
      idle($urandom_range(0, 2));
    end

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
